// File: rtl/chess_pkg.sv
// Shared types and constants for the chess move controller: square encoding,
// piece types, colours, controller states and the start-position builder.
package chess_pkg;

  typedef logic [4:0]       square_t;
  typedef logic [63:0][4:0] board_t;

  localparam logic [2:0] PAWN   = 3'b001;
  localparam logic [2:0] KNIGHT = 3'b010;
  localparam logic [2:0] BISHOP = 3'b011;
  localparam logic [2:0] ROOK   = 3'b100;
  localparam logic [2:0] QUEEN  = 3'b101;
  localparam logic [2:0] KING   = 3'b110;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam square_t EMPTY = 5'b00000;

  typedef enum logic [2:0] {
    ST_SEL_SRC = 3'd0,
    ST_SEL_DST = 3'd1,
    ST_CHECK   = 3'd2,
    ST_WR_DST  = 3'd3,
    ST_WR_SRC  = 3'd4
  } move_state_t;

  function automatic square_t mk_sq(input logic [2:0] kind, input logic colour);
    return {kind, colour, 1'b1};
  endfunction

  function automatic logic [2:0] back_rank(input int col);
    case (col)
      0, 7:    return ROOK;
      1, 6:    return KNIGHT;
      2, 5:    return BISHOP;
      3:       return QUEEN;
      default: return KING;
    endcase
  endfunction

  // Row 0 is black's back rank; index is {row,col}.
  function automatic board_t init_board();
    board_t b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[6'(c)]      = mk_sq(back_rank(c), BLACK);
      b[6'(8 + c)]  = mk_sq(PAWN, BLACK);
      b[6'(48 + c)] = mk_sq(PAWN, WHITE);
      b[6'(56 + c)] = mk_sq(back_rank(c), WHITE);
    end
    return b;
  endfunction

endpackage

// File: rtl/chess_move_ctrl_if.sv
// Legality-query handshake between the move controller and the move checker.
interface chess_move_ctrl_if;
  logic       chk_req;
  logic [5:0] chk_src;
  logic [5:0] chk_dst;
  logic       chk_ack;
  logic       chk_legal;

  modport master (output chk_req, chk_src, chk_dst, input chk_ack, chk_legal);
  modport slave  (input chk_req, chk_src, chk_dst, output chk_ack, chk_legal);
endinterface

// File: rtl/chess_cursor_ctrl.sv
// Board cursor: saturating row/column counters driven by debounced pulses.
module chess_cursor_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cursor,
  output logic [2:0] row,
  output logic [2:0] col
);
  logic up, down, left, right;

  assign up    = cursor[3];
  assign down  = cursor[2];
  assign left  = cursor[1];
  assign right = cursor[0];

  // Opposing pulses in the same cycle cancel on that axis.
  always_ff @(posedge clk) begin
    if (reset) begin
      row <= 3'd6;
      col <= 3'd4;
    end else if (en) begin
      if (up && !down && row != 3'd0)
        row <= row - 3'd1;
      else if (down && !up && row != 3'd7)
        row <= row + 3'd1;

      if (left && !right && col != 3'd0)
        col <= col - 3'd1;
      else if (right && !left && col != 3'd7)
        col <= col + 3'd1;
    end
  end
endmodule

// File: rtl/chess_move_ctrl.sv
// Board-state owner and single-move sequencer: select source and destination,
// query the checker, then commit the move over two write cycles.
module chess_move_ctrl
  import chess_pkg::*;
#(
  parameter int CHK_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                cursor,
  input  logic                      select,
  input  logic [2:0]                rd_row,
  input  logic [2:0]                rd_col,
  output logic [4:0]                rd_piece,
  output logic [2:0]                cur_row,
  output logic [2:0]                cur_col,
  output logic                      src_valid,
  output logic [2:0]                src_row,
  output logic [2:0]                src_col,
  output logic                      turn,
  output logic                      move_done,
  output logic                      move_reject,
  chess_move_ctrl_if.master         chk
);

  localparam logic [2:0] SEL_SRC = ST_SEL_SRC;
  localparam logic [2:0] SEL_DST = ST_SEL_DST;
  localparam logic [2:0] CHECK   = ST_CHECK;
  localparam logic [2:0] WR_DST  = ST_WR_DST;
  localparam logic [2:0] WR_SRC  = ST_WR_SRC;

  localparam int              TMO_W    = $clog2(CHK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CHK_TIMEOUT - 1);

  logic [2:0]       state;
  board_t           board;
  logic [5:0]       dst_sq;
  logic [TMO_W-1:0] tmo_cnt;
  logic             chk_req_q;

  logic [5:0] cur_sq;
  logic [5:0] src_sq;
  square_t    cur_piece;
  logic       cur_own;
  logic       cursor_en;

  assign cur_sq    = {cur_row, cur_col};
  assign src_sq    = {src_row, src_col};
  assign cur_piece = board[cur_sq];
  assign cur_own   = cur_piece[0] && (cur_piece[1] == turn);
  assign cursor_en = (state == SEL_SRC) || (state == SEL_DST);
  assign rd_piece  = board[{rd_row, rd_col}];

  assign chk.chk_req = chk_req_q;
  assign chk.chk_src = src_sq;
  assign chk.chk_dst = dst_sq;

  // Select acts on the pre-move cursor; the cursor updates on the same edge.
  chess_cursor_ctrl u_cursor (
    .clk    (clk),
    .reset  (reset),
    .en     (cursor_en),
    .cursor (cursor),
    .row    (cur_row),
    .col    (cur_col)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      board       <= init_board();
      state       <= SEL_SRC;
      src_valid   <= 1'b0;
      src_row     <= 3'd0;
      src_col     <= 3'd0;
      dst_sq      <= 6'd0;
      turn        <= WHITE;
      chk_req_q   <= 1'b0;
      move_done   <= 1'b0;
      move_reject <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      move_done   <= 1'b0;
      move_reject <= 1'b0;
      case (state)
        SEL_SRC: begin
          if (select && cur_own) begin
            src_row   <= cur_row;
            src_col   <= cur_col;
            src_valid <= 1'b1;
            state     <= SEL_DST;
          end
        end
        SEL_DST: begin
          if (select) begin
            if (cur_sq == src_sq) begin
              src_valid <= 1'b0;
              state     <= SEL_SRC;
            end else if (cur_own) begin
              src_row <= cur_row;
              src_col <= cur_col;
            end else begin
              dst_sq    <= cur_sq;
              tmo_cnt   <= '0;
              chk_req_q <= 1'b1;
              state     <= CHECK;
            end
          end
        end
        // An ack wins over a timeout expiring in the same cycle.
        CHECK: begin
          if (chk.chk_ack) begin
            chk_req_q <= 1'b0;
            if (chk.chk_legal) begin
              state <= WR_DST;
            end else begin
              move_reject <= 1'b1;
              src_valid   <= 1'b0;
              state       <= SEL_SRC;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            chk_req_q   <= 1'b0;
            move_reject <= 1'b1;
            src_valid   <= 1'b0;
            state       <= SEL_SRC;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        WR_DST: begin
          board[dst_sq] <= board[src_sq];
          state         <= WR_SRC;
        end
        WR_SRC: begin
          board[src_sq] <= EMPTY;
          turn          <= ~turn;
          src_valid     <= 1'b0;
          move_done     <= 1'b1;
          state         <= SEL_SRC;
        end
        default: state <= SEL_SRC;
      endcase
    end
  end

endmodule

// File: tb/tb_chess_move_ctrl.sv
// Scoreboard bench for chess_move_ctrl: directed moves push expected pulses,
// a monitor pops and checks them as move_done/move_reject appear.
module tb_chess_move_ctrl;

  localparam logic [3:0] UP    = 4'b1000;
  localparam logic [3:0] DOWN  = 4'b0100;
  localparam logic [3:0] LEFT  = 4'b0010;
  localparam logic [3:0] RIGHT = 4'b0001;
  localparam int         TMO   = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cursor;
  logic       select;
  logic [2:0] rd_row, rd_col;
  logic [4:0] rd_piece;
  logic [2:0] cur_row, cur_col;
  logic       src_valid;
  logic [2:0] src_row, src_col;
  logic       turn;
  logic       move_done, move_reject;

  chess_move_ctrl_if chk_if ();

  chess_move_ctrl #(.CHK_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cursor      (cursor),
    .select      (select),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_piece    (rd_piece),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .src_valid   (src_valid),
    .src_row     (src_row),
    .src_col     (src_col),
    .turn        (turn),
    .move_done   (move_done),
    .move_reject (move_reject),
    .chk         (chk_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int due;
    bit turn_after;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   sel_edge;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && (move_done === 1'b1 || move_reject === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b reject=%0b, expected none", move_done, move_reject);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_done", 32'(move_done), 32'(e.is_done));
        chk("pulse_kind_reject", 32'(move_reject), 32'(!e.is_done));
        chk("pulse_cycle", cyc, e.due);
        if (e.is_done) chk("turn_after_move", 32'(turn), 32'(e.turn_after));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] dir, input logic sel, input int n);
    for (int i = 0; i < n; i++) begin
      cursor   = dir;
      select   = sel;
      sel_edge = cyc + 1;
      tick();
      cursor = 4'b0;
      select = 1'b0;
    end
  endtask

  task automatic peek(input string name, input int r, input int c, input logic [4:0] exp);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
    chk(name, 32'(rd_piece), 32'(exp));
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    cursor           = 4'b0;
    select           = 1'b0;
    chk_if.chk_ack   = 1'b0;
    chk_if.chk_legal = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_exp(input bit is_done, input int lat, input bit turn_after);
    exp_t e;
    e.is_done    = is_done;
    e.due        = sel_edge + lat;
    e.turn_after = turn_after;
    exp_q.push_back(e);
  endtask

  task automatic ack_now(input logic legal);
    chk_if.chk_ack   = 1'b1;
    chk_if.chk_legal = legal;
    tick();
    chk_if.chk_ack   = 1'b0;
    chk_if.chk_legal = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    rd_row = 3'd0;
    rd_col = 3'd0;
    do_reset();

    // Reset state
    chk("rst_cur_row", 32'(cur_row), 6);
    chk("rst_cur_col", 32'(cur_col), 4);
    chk("rst_src_valid", 32'(src_valid), 0);
    chk("rst_turn", 32'(turn), 0);
    chk("rst_chk_req", 32'(chk_if.chk_req), 0);
    peek("rst_white_king", 7, 4, 5'b11001);
    peek("rst_black_queen", 0, 3, 5'b10111);
    peek("rst_empty_33", 3, 3, 5'b00000);

    // White pawn e2-e4 style: (6,4)->(4,4), ack on 2nd CHECK cycle
    press(UP, 1'b0, 1);
    press(4'b0, 1'b1, 1);
    chk("empty_select_ignored", 32'(src_valid), 0);
    press(DOWN, 1'b0, 1);
    press(4'b0, 1'b1, 1);
    chk("src_latched", 32'(src_valid), 1);
    chk("src_row", 32'(src_row), 6);
    press(UP, 1'b0, 2);
    press(4'b0, 1'b1, 1);
    chk("chk_req_high", 32'(chk_if.chk_req), 1);
    chk("chk_src", 32'(chk_if.chk_src), 32'(6'b110100));
    chk("chk_dst", 32'(chk_if.chk_dst), 32'(6'b100100));
    push_exp(1'b1, 4, 1'b1);
    tick();
    ack_now(1'b1);
    chk("chk_req_drops", 32'(chk_if.chk_req), 0);
    repeat (4) tick();
    peek("move1_src_empty", 6, 4, 5'b00000);
    peek("move1_dst_pawn", 4, 4, 5'b00101);
    chk("move1_src_valid", 32'(src_valid), 0);

    // Black reply (1,4)->(3,4), same-cycle ack: minimum latency
    press(UP, 1'b0, 3);
    press(4'b0, 1'b1, 1);
    chk("black_src_latched", 32'(src_valid), 1);
    press(DOWN, 1'b0, 2);
    press(4'b0, 1'b1, 1);
    push_exp(1'b1, 3, 1'b0);
    ack_now(1'b1);
    repeat (4) tick();
    peek("move2_src_empty", 1, 4, 5'b00000);
    peek("move2_dst_pawn", 3, 4, 5'b00111);

    // Cursor saturation and opposing pulses
    do_reset();
    press(UP, 1'b0, 7);
    chk("sat_row_top", 32'(cur_row), 0);
    press(LEFT | RIGHT, 1'b0, 1);
    chk("lr_cancel_col", 32'(cur_col), 4);
    press(UP | DOWN, 1'b0, 1);
    chk("ud_cancel_row", 32'(cur_row), 0);
    press(RIGHT, 1'b0, 5);
    chk("sat_col_right", 32'(cur_col), 7);
    press(DOWN, 1'b0, 9);
    chk("sat_row_bottom", 32'(cur_row), 7);

    // White may not select a black piece
    do_reset();
    press(UP, 1'b0, 5);
    press(LEFT, 1'b0, 4);
    press(4'b0, 1'b1, 1);
    chk("black_piece_ignored", 32'(src_valid), 0);
    press(DOWN, 1'b0, 5);
    press(4'b0, 1'b1, 1);
    chk("still_sel_src", 32'(src_valid), 1);
    chk("still_sel_src_col", 32'(src_col), 0);

    // Cancel, re-latch, select with simultaneous move
    do_reset();
    press(LEFT, 1'b1, 1);
    chk("sel_pre_move_col", 32'(src_col), 4);
    chk("cursor_moved", 32'(cur_col), 3);
    press(4'b0, 1'b1, 1);
    chk("relatch_col", 32'(src_col), 3);
    chk("relatch_valid", 32'(src_valid), 1);
    press(4'b0, 1'b1, 1);
    chk("cancel_valid", 32'(src_valid), 0);
    chk("cancel_no_req", 32'(chk_if.chk_req), 0);
    peek("cancel_board_63", 6, 3, 5'b00101);

    // Checker timeout
    do_reset();
    press(4'b0, 1'b1, 1);
    press(UP, 1'b0, 2);
    press(4'b0, 1'b1, 1);
    push_exp(1'b0, TMO, 1'b0);
    begin
      int n;
      n = 0;
      while (chk_if.chk_req === 1'b1 && n < TMO + 50) begin
        n++;
        tick();
      end
      chk("timeout_req_cycles", n, TMO);
    end
    repeat (2) tick();
    peek("timeout_src_kept", 6, 4, 5'b00101);
    peek("timeout_dst_empty", 4, 4, 5'b00000);
    chk("timeout_turn", 32'(turn), 0);
    chk("timeout_src_valid", 32'(src_valid), 0);

    // Reset while in WR_DST
    do_reset();
    press(4'b0, 1'b1, 1);
    press(UP, 1'b0, 2);
    press(4'b0, 1'b1, 1);
    ack_now(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    peek("abort_src_kept", 6, 4, 5'b00101);
    peek("abort_dst_empty", 4, 4, 5'b00000);
    chk("abort_turn", 32'(turn), 0);
    chk("abort_cur_row", 32'(cur_row), 6);

    // Illegal verdict
    press(4'b0, 1'b1, 1);
    press(UP, 1'b0, 2);
    press(4'b0, 1'b1, 1);
    push_exp(1'b0, 1, 1'b0);
    ack_now(1'b0);
    chk("illegal_req_low", 32'(chk_if.chk_req), 0);
    chk("illegal_src_valid", 32'(src_valid), 0);
    press(DOWN, 1'b0, 2);
    chk("illegal_cursor_live", 32'(cur_row), 6);
    press(4'b0, 1'b1, 1);
    chk("illegal_back_sel_src", 32'(src_valid), 1);
    peek("illegal_dst_empty", 4, 4, 5'b00000);
    chk("illegal_turn", 32'(turn), 0);

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
